// File: rtl/sobel_edge_stream.sv
// rtl/sobel_edge_stream.sv - streaming 3x3 Sobel edge magnitude with line buffers
// Border pixels are dropped; output is saturated magnitude (MODE=0) or thresholded (MODE=1).
module sobel_edge_stream #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_sof,
  input  logic [PIX_W-1:0] thresh,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_eof
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = PIX_W + 3;
  localparam int MW = PIX_W + 4;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic          adv, accept;
  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] top_in, mid_in;
  logic [PIX_W-1:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;

  logic                 w_valid, w_eof, s1_valid, s1_eof;
  logic signed [GW-1:0] gx, gy, gx_c, gy_c;
  logic [GW-1:0]        ax, ay;
  logic [MW-1:0]        mag;
  logic [PIX_W-1:0]     res, thresh_q;

  assign adv     = !m_valid || m_ready;
  assign s_ready = adv;
  assign accept  = s_valid && adv && !rst;

  // An s_sof pixel restarts the frame regardless of where the counters are.
  assign cur_col = s_sof ? '0 : col;
  assign cur_row = s_sof ? '0 : row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  assign top_in = lb1[cur_col];
  assign mid_in = lb0[cur_col];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[cur_col] <= mid_in;
      lb0[cur_col] <= s_data;
      p00 <= p01;  p01 <= p02;  p02 <= top_in;
      p10 <= p11;  p11 <= p12;  p12 <= mid_in;
      p20 <= p21;  p21 <= p22;  p22 <= s_data;
    end
  end

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] v);
    return $signed({3'b000, v});
  endfunction

  always_comb begin
    gx_c = (ext(p02) + (ext(p12) <<< 1) + ext(p22)) - (ext(p00) + (ext(p10) <<< 1) + ext(p20));
    gy_c = (ext(p20) + (ext(p21) <<< 1) + ext(p22)) - (ext(p00) + (ext(p01) <<< 1) + ext(p02));
  end

  always_comb begin
    ax  = gx[GW-1] ? -gx : gx;
    ay  = gy[GW-1] ? -gy : gy;
    mag = {1'b0, ax} + {1'b0, ay};
    res = '0;
    if (MODE == 0)
      res = (|mag[MW-1:PIX_W]) ? '1 : mag[PIX_W-1:0];
    else
      res = (mag >= {4'b0000, thresh_q}) ? '1 : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_valid  <= 1'b0;
      w_eof    <= 1'b0;
      s1_valid <= 1'b0;
      s1_eof   <= 1'b0;
      gx       <= '0;
      gy       <= '0;
      m_valid  <= 1'b0;
      m_eof    <= 1'b0;
      m_data   <= '0;
      thresh_q <= '0;
    end else begin
      if (adv) begin
        w_valid  <= accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        w_eof    <= accept && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        s1_valid <= w_valid;
        s1_eof   <= w_eof;
        gx       <= gx_c;
        gy       <= gy_c;
        m_valid  <= s1_valid;
        m_eof    <= s1_eof;
        m_data   <= res;
      end
      if (accept && s_sof)
        thresh_q <= thresh;
    end
  end

endmodule

// File: tb/tb_sobel_edge_stream.sv
// tb/tb_sobel_edge_stream.sv - directed bench for sobel_edge_stream, 8x6 image, both modes
module tb_sobel_edge_stream;

  logic       clk = 1'b0;
  logic       rst, s_valid, s_sof, m_ready;
  logic [7:0] s_data, thresh;
  logic       s_ready0, m_valid0, m_eof0, s_ready1, m_valid1, m_eof1;
  logic [7:0] m_data0, m_data1;

  int checks = 0, errors = 0, cyc = 0, acc22 = 0, first_mv = -1;
  bit stall_en = 0, prev_stall = 0;
  logic [8:0] held;
  logic [8:0] q0 [$];
  logic [8:0] q1 [$];

  always #5 clk = ~clk;

  sobel_edge_stream #(.PIX_W(8), .IMG_W(8), .IMG_H(6), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
    .s_sof(s_sof), .thresh(thresh), .m_valid(m_valid0), .m_ready(m_ready),
    .m_data(m_data0), .m_eof(m_eof0));

  sobel_edge_stream #(.PIX_W(8), .IMG_W(8), .IMG_H(6), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
    .s_sof(s_sof), .thresh(thresh), .m_valid(m_valid1), .m_ready(m_ready),
    .m_data(m_data1), .m_eof(m_eof1));

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (stall_en) m_ready = 1'($urandom_range(0, 1));
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (m_valid0 !== 1'b1 || {m_eof0, m_data0} !== held) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b %h required v=1 %h", m_valid0, {m_eof0, m_data0}, held);
        end
      end
      prev_stall = m_valid0 && !m_ready;
      held = {m_eof0, m_data0};
      if (m_valid0 && m_ready) q0.push_back({m_eof0, m_data0});
      if (m_valid1 && m_ready) q1.push_back({m_eof1, m_data1});
      if (m_valid0 && first_mv < 0) first_mv = cyc;
    end
  end

  function automatic logic [7:0] pix(input int kind, input int c);
    case (kind)
      0:       return 8'd50;
      1:       return 8'(10 * c);
      default: return (c < 4) ? 8'd0 : 8'd100;
    endcase
  endfunction

  // Hand-derived results: constant -> 0, ramp -> 80, step -> 255 at centre cols 3,4.
  function automatic logic [7:0] exp_pix(input int kind, input int mode, input int th, input int c);
    if (mode == 1) return (80 >= th) ? 8'hff : 8'h00;
    case (kind)
      0:       return 8'd0;
      1:       return 8'd80;
      default: return (c == 3 || c == 4) ? 8'd255 : 8'd0;
    endcase
  endfunction

  task automatic send_frame(input int kind, input bit sof_first, input int npix, input int th_mid);
    for (int i = 0; i < npix; i++) begin
      int r, c, n;
      r = i / 8;
      c = i % 8;
      if (th_mid >= 0 && i == 20) thresh = 8'(th_mid);
      s_valid = 1'b1;
      s_data  = pix(kind, c);
      s_sof   = (i == 0) && sof_first;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!s_ready0 && n < 500);
      if (!s_ready0) begin
        checks++;
        errors++;
        $display("FAIL input_timeout: got s_ready=0 required 1 at pixel %0d", i);
      end
      @(posedge clk);
      #1;
      if (r == 2 && c == 2) acc22 = cyc;
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic drain(input int n);
    int k = 0;
    while (q0.size() < n && k < 2000) begin
      @(posedge clk);
      k++;
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; m_ready = 1'b1; thresh = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (m_valid0 !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b required 0", m_valid0); end
    checks++; if (m_data0 !== 8'h00) begin errors++; $display("FAIL rst_m_data: got %h required 00", m_data0); end
    checks++; if (m_eof0 !== 1'b0) begin errors++; $display("FAIL rst_m_eof: got %b required 0", m_eof0); end
    checks++; if (s_ready0 !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %b required 1", s_ready0); end
    checks++; if (m_valid1 !== 1'b0) begin errors++; $display("FAIL rst_m_valid1: got %b required 0", m_valid1); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_constant();
    q0.delete(); q1.delete(); first_mv = -1;
    send_frame(0, 1, 48, -1);
    drain(24);
    checks++; if (q0.size() != 24) begin errors++; $display("FAIL const_count: got %0d required 24", q0.size()); end
    for (int i = 0; i < q0.size(); i++) begin
      checks++;
      if (q0[i] !== {(i == 23), exp_pix(0, 0, 0, i % 6 + 1)}) begin
        errors++; $display("FAIL const[%0d]: got %h required %h", i, q0[i], {(i == 23), exp_pix(0, 0, 0, i % 6 + 1)});
      end
    end
    checks++; if (first_mv - acc22 != 2) begin errors++; $display("FAIL latency: got %0d required 2", first_mv - acc22); end
  endtask

  task automatic test_ramp();
    q0.delete(); q1.delete();
    send_frame(1, 1, 48, -1);
    drain(24);
    checks++; if (q0.size() != 24) begin errors++; $display("FAIL ramp_count: got %0d required 24", q0.size()); end
    for (int i = 0; i < q0.size(); i++) begin
      checks++;
      if (q0[i] !== {(i == 23), exp_pix(1, 0, 0, i % 6 + 1)}) begin
        errors++; $display("FAIL ramp[%0d]: got %h required %h", i, q0[i], {(i == 23), exp_pix(1, 0, 0, i % 6 + 1)});
      end
    end
  endtask

  task automatic test_step();
    q0.delete(); q1.delete();
    send_frame(2, 1, 48, -1);
    drain(24);
    checks++; if (q0.size() != 24) begin errors++; $display("FAIL step_count: got %0d required 24", q0.size()); end
    for (int i = 0; i < q0.size(); i++) begin
      checks++;
      if (q0[i] !== {(i == 23), exp_pix(2, 0, 0, i % 6 + 1)}) begin
        errors++; $display("FAIL step[%0d]: got %h required %h", i, q0[i], {(i == 23), exp_pix(2, 0, 0, i % 6 + 1)});
      end
    end
  endtask

  task automatic test_threshold();
    int th_sof [4] = '{100, 80, 80, 100};
    int th_mid [4] = '{-1, -1, 100, -1};
    for (int f = 0; f < 4; f++) begin
      q0.delete(); q1.delete();
      thresh = 8'(th_sof[f]);
      send_frame(1, 1, 48, th_mid[f]);
      drain(24);
      checks++; if (q1.size() != 24) begin errors++; $display("FAIL thr%0d_count: got %0d required 24", f, q1.size()); end
      for (int i = 0; i < q1.size(); i++) begin
        checks++;
        if (q1[i] !== {(i == 23), exp_pix(1, 1, th_sof[f], 0)}) begin
          errors++; $display("FAIL thr%0d[%0d]: got %h required %h", f, i, q1[i], {(i == 23), exp_pix(1, 1, th_sof[f], 0)});
        end
      end
    end
  endtask

  task automatic test_stall();
    q0.delete(); q1.delete();
    stall_en = 1;
    send_frame(2, 1, 48, -1);
    drain(24);
    stall_en = 0;
    m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (q0.size() != 24) begin errors++; $display("FAIL stall_count: got %0d required 24", q0.size()); end
    for (int i = 0; i < q0.size(); i++) begin
      checks++;
      if (q0[i] !== {(i == 23), exp_pix(2, 0, 0, i % 6 + 1)}) begin
        errors++; $display("FAIL stall[%0d]: got %h required %h", i, q0[i], {(i == 23), exp_pix(2, 0, 0, i % 6 + 1)});
      end
    end
  endtask

  task automatic test_reset_mid();
    send_frame(2, 1, 29, -1);
    rst = 1'b1;
    #1;
    checks++; if (m_valid0 !== 1'b0) begin errors++; $display("FAIL rstmid_m_valid: got %b required 0", m_valid0); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q0.delete(); q1.delete();
    send_frame(1, 0, 48, -1);
    drain(24);
    checks++; if (q0.size() != 24) begin errors++; $display("FAIL rstmid_count: got %0d required 24", q0.size()); end
    for (int i = 0; i < q0.size(); i++) begin
      checks++;
      if (q0[i] !== {(i == 23), exp_pix(1, 0, 0, i % 6 + 1)}) begin
        errors++; $display("FAIL rstmid[%0d]: got %h required %h", i, q0[i], {(i == 23), exp_pix(1, 0, 0, i % 6 + 1)});
      end
    end
  endtask

  task automatic test_sof_mid();
    logic [8:0] e;
    q0.delete(); q1.delete();
    send_frame(1, 1, 20, -1);
    send_frame(2, 1, 48, -1);
    drain(26);
    checks++; if (q0.size() != 26) begin errors++; $display("FAIL sofmid_count: got %0d required 26", q0.size()); end
    for (int i = 0; i < q0.size(); i++) begin
      e = (i < 2) ? {1'b0, 8'd80} : {(i == 25), exp_pix(2, 0, 0, (i - 2) % 6 + 1)};
      checks++;
      if (q0[i] !== e) begin errors++; $display("FAIL sofmid[%0d]: got %h required %h", i, q0[i], e); end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_step();
    test_threshold();
    test_stall();
    test_reset_mid();
    test_sof_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
